// File: rtl/lex_pkg.sv
// rtl/lex_pkg.sv - token kinds, error codes and character constants shared by the lexer front end
package lex_pkg;

  typedef enum logic [2:0] {
    TOK_CHAR    = 3'd0,
    TOK_NEWLINE = 3'd1,
    TOK_INDENT  = 3'd2,
    TOK_DEDENT  = 3'd3,
    TOK_EOF     = 3'd4,
    TOK_ERROR   = 3'd5
  } tok_kind_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_DEPTH = 2'd2
  } err_code_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NL    = 8'h0a;

  localparam int DEFAULT_INDENT_WIDTH = 4;

endpackage

// File: rtl/tok_out_slice.sv
// rtl/tok_out_slice.sv - single-entry valid/ready register holding one output token
module tok_out_slice
  import lex_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  tok_kind_e  push_kind,
  input  logic [7:0] push_char,
  output logic       free,
  output logic       out_valid,
  input  logic       out_ready,
  output tok_kind_e  out_kind,
  output logic [7:0] out_char
);

  assign free = !out_valid || out_ready;

  // A push is only honoured when the slot is free, so a stalled token never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_kind  <= TOK_CHAR;
      out_char  <= 8'h00;
    end else if (push && free) begin
      out_valid <= 1'b1;
      out_kind  <= push_kind;
      out_char  <= (push_kind == TOK_CHAR) ? push_char : 8'h00;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/indent_token_sequencer.sv
// rtl/indent_token_sequencer.sv - line-structure front end: indentation tracking and
// INDENT/DEDENT/NEWLINE/EOF/ERROR insertion ahead of the scanner
module indent_token_sequencer
  import lex_pkg::*;
#(
  parameter int INDENT_WIDTH = DEFAULT_INDENT_WIDTH,
  parameter int MAX_LEVEL    = 15,
  parameter int LEVEL_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_char,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output tok_kind_e          out_kind,
  output logic [7:0]         out_char,
  output logic [LEVEL_W-1:0] level,
  output err_code_e          err_code,
  output logic               busy
);

  localparam int SAT_I = INDENT_WIDTH * (MAX_LEVEL + 1);
  localparam int SPC_W = $clog2(SAT_I) + 1;
  localparam logic [SPC_W-1:0] SPC_SAT  = SPC_W'(SAT_I);
  localparam logic [SPC_W-1:0] SPC_IW   = SPC_W'(INDENT_WIDTH);
  localparam logic [SPC_W-1:0] SPC_MAXL = SPC_W'(MAX_LEVEL);

  typedef enum logic [3:0] {
    S_IDLE, S_LINE_START, S_FLUSH_IND, S_EMIT_HELD, S_BODY,
    S_EMIT_NL, S_EMIT_EOF, S_ERR, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SPC_W-1:0]   spc_q, spc_d;
  logic [LEVEL_W-1:0] tgt_q, tgt_d, level_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_last_q, hold_last_d;
  err_code_e          err_d;

  logic               push, free, accept;
  tok_kind_e          push_kind;
  logic [7:0]         push_char;
  logic [SPC_W-1:0]   spc_lvl, spc_rem;

  assign spc_lvl  = spc_q / SPC_IW;
  assign spc_rem  = spc_q % SPC_IW;
  assign in_ready = (state_q == S_LINE_START || state_q == S_BODY) && free;
  assign accept   = in_valid && in_ready;
  // busy covers the final EOF/ERROR until downstream has taken it
  assign busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) || out_valid;

  always_comb begin
    state_d     = state_q;
    spc_d       = spc_q;
    tgt_d       = tgt_q;
    level_d     = level;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    err_d       = err_code;
    push        = 1'b0;
    push_kind   = TOK_CHAR;
    push_char   = 8'h00;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LINE_START;
          spc_d   = '0;
          level_d = '0;
          err_d   = ERR_NONE;
        end
      end
      S_LINE_START: begin
        if (accept) begin
          if (in_char == ASCII_SPACE) begin
            if (spc_q != SPC_SAT) spc_d = spc_q + 1'b1;
            if (in_last) state_d = S_EMIT_EOF;
          end else if (in_char == ASCII_NL) begin
            spc_d = '0;
            if (in_last) state_d = S_EMIT_EOF;
          end else begin
            hold_d      = in_char;
            hold_last_d = in_last;
            spc_d       = '0;
            if (spc_rem != '0) begin
              err_d     = ERR_ALIGN;
              push      = 1'b1;
              push_kind = TOK_ERROR;
              state_d   = S_ERR;
            end else if (spc_lvl > SPC_MAXL) begin
              err_d     = ERR_DEPTH;
              push      = 1'b1;
              push_kind = TOK_ERROR;
              state_d   = S_ERR;
            end else begin
              tgt_d   = LEVEL_W'(spc_lvl);
              state_d = S_FLUSH_IND;
            end
          end
        end
      end
      S_FLUSH_IND: begin
        if (level == tgt_q) begin
          state_d = S_EMIT_HELD;
        end else if (free) begin
          push = 1'b1;
          if (level < tgt_q) begin
            push_kind = TOK_INDENT;
            level_d   = level + 1'b1;
          end else begin
            push_kind = TOK_DEDENT;
            level_d   = level - 1'b1;
          end
        end
      end
      S_EMIT_HELD: begin
        if (free) begin
          push      = 1'b1;
          push_char = hold_q;
          state_d   = hold_last_q ? S_EMIT_NL : S_BODY;
        end
      end
      S_BODY: begin
        if (accept) begin
          push = 1'b1;
          if (in_char == ASCII_NL) begin
            push_kind = TOK_NEWLINE;
            state_d   = in_last ? S_EMIT_EOF : S_LINE_START;
          end else begin
            push_char = in_char;
            if (in_last) state_d = S_EMIT_NL;
          end
        end
      end
      S_EMIT_NL: begin
        if (free) begin
          push      = 1'b1;
          push_kind = TOK_NEWLINE;
          state_d   = S_EMIT_EOF;
        end
      end
      S_EMIT_EOF: begin
        if (free) begin
          push      = 1'b1;
          push_kind = TOK_EOF;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      spc_q       <= '0;
      tgt_q       <= '0;
      level       <= '0;
      hold_q      <= 8'h00;
      hold_last_q <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      spc_q       <= spc_d;
      tgt_q       <= tgt_d;
      level       <= level_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      err_code    <= err_d;
    end
  end

  tok_out_slice u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_kind (push_kind),
    .push_char (push_char),
    .free      (free),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_char  (out_char)
  );

endmodule

// File: doc/indent_token_sequencer.md
Name: indent_token_sequencer

Overview:
Line-structure front end of the hardware lexer; sits between the source character stream and the token scanner.
Tracks line starts and counts leading spaces, drops blank lines, and inserts INDENT, DEDENT, NEWLINE, EOF and ERROR tokens.
Forwards every other character, tagged CHAR, to the downstream scanner on one ordered output stream.
Token order is bit-exact with the interpreter's software tokenizer, so both share golden files.

Parameters:
INDENT_WIDTH, 4, spaces per indentation level
MAX_LEVEL, 15, deepest legal indentation level
LEVEL_W, 4, width of level counter (holds 0..MAX_LEVEL)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new source stream
in_valid  in  1  source char valid
in_ready  out  1  source char accepted when in_valid&&in_ready
in_char  in  8  source byte
in_last  in  1  marks final byte of the stream
out_valid  out  1  token valid
out_ready  in  1  downstream accepts token
out_kind  out  3  lex_pkg::tok_kind_e: CHAR=0 NEWLINE=1 INDENT=2 DEDENT=3 EOF=4 ERROR=5
out_char  out  8  byte for CHAR; 0 otherwise
level  out  LEVEL_W  current indentation level
err_code  out  2  0 none, 1 indent not multiple of INDENT_WIDTH, 2 level > MAX_LEVEL
busy  out  1  high from start until EOF/ERROR accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, out_kind=0, out_char=0, level=0, err_code=0, busy=0, in_ready=0. A reset mid-stream drops any pending token.
- Output register: out_* stay stable while out_valid && !out_ready. A new token loads only when !out_valid || out_ready.
- FSM states: IDLE, LINE_START, FLUSH_IND, EMIT_HELD, BODY, EMIT_NL, EMIT_EOF, ERR, DONE.
- start: legal in IDLE/DONE/ERR only, ignored otherwise. Clears level, space count and err_code; goes to LINE_START.
- LINE_START: in_ready=1 whenever the output slot is free.
  - ' ' increments the saturating space count.
  - '\n' means a blank line: clear space count, emit nothing, stay in LINE_START.
  - Any other byte: latch it in hold register, then check the count.
    - count % INDENT_WIDTH != 0 -> err 1.
    - count/INDENT_WIDTH > MAX_LEVEL -> err 2.
    - Otherwise target = count/INDENT_WIDTH; go to FLUSH_IND.
- FLUSH_IND: in_ready=0. Emit one INDENT (level+1) or DEDENT (level-1) per accepted token until level == target. Multi-level jumps emit several tokens, no error. Then go to EMIT_HELD.
- EMIT_HELD: emit CHAR(hold); go to BODY.
- BODY: in_ready = !out_valid || out_ready; latency 1 cycle input to out_valid.
  - Spaces and all non-'\n' bytes (tab, CR included) pass through as CHAR.
  - '\n' emits NEWLINE, then LINE_START.
- in_last on the final byte:
  - Final byte processed normally first.
  - If the line is non-blank and unterminated, emit NEWLINE.
  - Then EOF, then DONE (in_ready=0).
  - No closing DEDENTs before EOF, matching software.
  - in_last on a blank or space-only line goes straight to EOF.
  - in_last on the byte latched in LINE_START is honoured after FLUSH_IND/EMIT_HELD.
- Error: err_code is set in the same cycle the violation is detected. Emit one ERROR token, then ERR state with in_ready=0, err_code held until start or reset.
- Space count saturates at INDENT_WIDTH*(MAX_LEVEL+1). Width is clog2(INDENT_WIDTH*(MAX_LEVEL+1))+1.
- in_valid while in IDLE/DONE/ERR: not accepted, no effect.

Decomposition:
- lex_pkg: tok_kind_e, err_code_e, ASCII_SPACE/ASCII_NL constants, INDENT_WIDTH default.
- Shared with the scanner and the parser front end.
- One sub-module: tok_out_slice, a single-entry valid/ready register for out_kind/out_char. Reused by the scanner.

Test Plan:
- start; "a\n    b\nc" with in_last on 'c', out_ready=1 -> CHAR a, NL, INDENT, CHAR b, NL, DEDENT, CHAR c, NL, EOF. level ends 0; busy drops after EOF.
- "x\n\n   \n        y\n" -> CHAR x, NL, INDENT, INDENT, CHAR y, NL, EOF. Blank lines produce no tokens; level=2.
- "x\n  y" -> CHAR x, NL, ERROR with err_code=1; in_ready=0 afterwards. start clears err_code to 0.
- 64 spaces then 'z', MAX_LEVEL=15 -> ERROR, err_code=2, no INDENT emitted.
- "ab c\n" with out_ready toggling 1,0,0,1,... -> out_* stable while stalled. Tokens CHAR a, CHAR b, CHAR ' ', CHAR c, NL, EOF; no loss or duplication.
- rst_n asserted while FLUSH_IND is holding an INDENT with out_ready=0 -> out_valid=0, level=0, state IDLE; in_ready stays 0 until start.
